// File: rtl/trigger_cond_if.sv
// trigger_cond_if: control/status bundle between the trigger front-end and its controller.
// The master side drives the raw trigger and the arming controls; the slave side is
// trigger_cond itself.
interface trigger_cond_if #(
  parameter int unsigned FILT_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              trig_raw_i;
  logic              arm_i;
  logic [1:0]        edge_sel_i;
  logic [FILT_W-1:0] filt_len_i;
  logic [CNT_W-1:0]  count_i;
  logic              trigger_o;
  logic              armed_o;
  logic              done_o;

  modport master (
    output trig_raw_i, arm_i, edge_sel_i, filt_len_i, count_i,
    input  trigger_o, armed_o, done_o
  );

  modport slave (
    input  trig_raw_i, arm_i, edge_sel_i, filt_len_i, count_i,
    output trigger_o, armed_o, done_o
  );
endinterface

// File: rtl/trigger_cond.sv
// trigger_cond: synchronises the raw pad trigger, optionally deglitches it, selects an
// edge/level event and fires one single-cycle trigger per arming on the Nth event.
// Optional glitch filter: define TRIG_FILTER_EN to build it; otherwise filt = sync.
module trigger_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8,
  parameter int unsigned CNT_W       = 16
) (
  input logic           clk,
  input logic           rst,
  trigger_cond_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_filt;
  logic                   r_prev;
  logic                   w_evt;
  state_e                 r_state;
  state_e                 w_state_d;
  logic                   w_fire;
  logic [1:0]             r_sel;
  logic [CNT_W-1:0]       r_rem;
  logic [CNT_W-1:0]       w_rem_load;
  logic                   r_trig;
  logic                   r_armed;
  logic                   r_done;

  // Synchroniser chain: the raw pad enters at bit 0, the last stage is the clean copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.trig_raw_i};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef TRIG_FILTER_EN
  logic              r_filt;
  logic [FILT_W-1:0] r_diff_cnt;
  logic [FILT_W:0]   w_cnt_inc;

  // One extra bit so the compare against filt_len_i cannot wrap.
  assign w_cnt_inc = {1'b0, r_diff_cnt} + {{FILT_W{1'b0}}, 1'b1};

  // Glitch filter: follow sync only after it has differed for filt_len_i consecutive edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt     <= 1'b0;
      r_diff_cnt <= '0;
    end else if (bus.filt_len_i == '0) begin
      r_filt     <= w_sync;
      r_diff_cnt <= '0;
    end else if (w_sync == r_filt) begin
      r_diff_cnt <= '0;
    end else if (w_cnt_inc >= {1'b0, bus.filt_len_i}) begin
      r_filt     <= w_sync;
      r_diff_cnt <= '0;
    end else begin
      r_diff_cnt <= w_cnt_inc[FILT_W-1:0];
    end
  end

  // Length 0 bypasses the register so the filter adds no latency.
  assign w_filt = (bus.filt_len_i == '0) ? w_sync : r_filt;
`else
  assign w_filt = w_sync;
`endif

  // Previous filtered value for edge detection, tracked in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_filt;
    end
  end

  // Qualified event for the event type latched at arming.
  always_comb begin
    w_evt = 1'b0;
    unique case (r_sel)
      2'b00:   w_evt = w_filt & ~r_prev;
      2'b01:   w_evt = ~w_filt & r_prev;
      2'b10:   w_evt = w_filt ^ r_prev;
      default: w_evt = w_filt;
    endcase
  end

  assign w_rem_load = (bus.count_i == '0) ? CntOne : bus.count_i;

  // Next-state: disarm has priority over a firing event.
  always_comb begin
    w_state_d = r_state;
    w_fire    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.arm_i) w_state_d = StArmed;
      end
      StArmed: begin
        if (!bus.arm_i) begin
          w_state_d = StIdle;
        end else if (w_evt && ((r_sel == 2'b11) || (r_rem == CntOne))) begin
          w_state_d = StDone;
          w_fire    = 1'b1;
        end
      end
      StDone: begin
        if (!bus.arm_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Event type and remaining count are captured at arming and frozen while armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 2'b00;
      r_rem <= '0;
    end else if ((r_state == StIdle) && bus.arm_i) begin
      r_sel <= bus.edge_sel_i;
      r_rem <= w_rem_load;
    end else if ((r_state == StArmed) && bus.arm_i && w_evt && !w_fire) begin
      r_rem <= r_rem - CntOne;
    end
  end

  // Registered outputs; the trigger is the first cycle of DONE as seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig  <= 1'b0;
      r_armed <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_trig  <= (r_state == StDone) & ~r_done;
      r_armed <= (r_state == StArmed);
      r_done  <= (r_state == StDone);
    end
  end

  assign bus.trigger_o = r_trig;
  assign bus.armed_o   = r_armed;
  assign bus.done_o    = r_done;

endmodule

// File: tb/tb_trigger_cond.sv
// tb_trigger_cond: directed scenarios plus randomized stimulus against a history-based
// reference model; expected trigger edges go into a queue checked by a negedge monitor.
module tb_trigger_cond;

  localparam int S    = 2;
  localparam int FW   = 8;
  localparam int CW   = 16;
  localparam int MAXC = 8192;
`ifdef TRIG_FILTER_EN
  localparam bit FiltEn = 1'b1;
`else
  localparam bit FiltEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  trigger_cond_if #(.FILT_W(FW), .CNT_W(CW)) bus ();

  trigger_cond #(
    .SYNC_STAGES(S),
    .FILT_W     (FW),
    .CNT_W      (CW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  int checks    = 0;
  int passed    = 0;
  int n         = 0;   // edges seen since the last reset release
  int trig_seen = 0;
  int exp_q[$];        // edge indices at which trigger_o must be high

  bit raw_a  [MAXC];
  bit sync_a [MAXC];
  bit freg_a [MAXC];
  bit filt_a [MAXC];
  int st_a   [MAXC];   // 0 idle, 1 armed, 2 done after each edge

  int m_st, m_mode, m_target, m_seen;
  int mi, ml;
  bit fprev, alld, f1, f2, ev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n - 1);
  endtask

  // Reference model: sync is the raw value S-1 edges ago; filt follows sync once sync has
  // disagreed for L consecutive samples; events and the arming rules are applied per edge.
  initial begin
    m_st = 0; m_mode = 0; m_target = 1; m_seen = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0;
        m_st = 0;
        exp_q.delete();
      end else if (n < MAXC) begin
        mi = n;
        raw_a[mi]  = bus.trig_raw_i;
        sync_a[mi] = (mi >= S - 1) ? raw_a[mi-S+1] : 1'b0;
        ml    = FiltEn ? int'(bus.filt_len_i) : 0;
        fprev = (mi > 0) ? freg_a[mi-1] : 1'b0;
        if (ml == 0) begin
          freg_a[mi] = (mi > 0) ? sync_a[mi-1] : 1'b0;
        end else begin
          alld = 1'b1;
          for (int j = mi - ml; j < mi; j++) begin
            if (j < 0) alld = 1'b0;
            else if (sync_a[j] == fprev) alld = 1'b0;
          end
          freg_a[mi] = alld ? sync_a[mi-1] : fprev;
        end
        filt_a[mi] = (ml == 0) ? sync_a[mi] : freg_a[mi];
        f1 = (mi >= 1) ? filt_a[mi-1] : 1'b0;
        f2 = (mi >= 2) ? filt_a[mi-2] : 1'b0;
        case (m_mode)
          0:       ev = f1 && !f2;
          1:       ev = !f1 && f2;
          2:       ev = (f1 != f2);
          default: ev = f1;
        endcase
        case (m_st)
          0: begin
            if (bus.arm_i) begin
              m_st     = 1;
              m_mode   = int'(bus.edge_sel_i);
              m_target = (bus.count_i == '0) ? 1 : int'(bus.count_i);
              m_seen   = 0;
            end
          end
          1: begin
            if (!bus.arm_i) begin
              m_st = 0;
            end else if (ev) begin
              m_seen++;
              if (m_mode == 3 || m_seen >= m_target) begin
                m_st = 2;
                exp_q.push_back(mi + 1);
              end
            end
          end
          default: begin
            if (!bus.arm_i) m_st = 0;
          end
        endcase
        st_a[mi] = m_st;
        n = mi + 1;
      end
    end
  end

  // Monitor: outputs after edge e reflect the model state after edge e-1.
  initial begin
    int last, ps;
    bit et;
    forever begin
      @(negedge clk);
      if (!rst && n > 0) begin
        last = n - 1;
        ps   = (last >= 1) ? st_a[last-1] : 0;
        et   = (exp_q.size() > 0) && (exp_q[0] == last);
        if (et) void'(exp_q.pop_front());
        chk("armed_o", int'(bus.armed_o), int'(ps == 1));
        chk("done_o", int'(bus.done_o), int'(ps == 2));
        chk("trigger_o", int'(bus.trigger_o), int'(et));
        if (bus.trigger_o) trig_seen++;
      end
    end
  end

  task automatic tick(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic wait_trig(input int budget, output int idx);
    idx = -1;
    for (int b = 0; b < budget; b++) begin
      @(negedge clk);
      if (bus.trigger_o) begin
        idx = n - 1;
        break;
      end
    end
  endtask

  initial begin
    int k, t, base;
    bus.trig_raw_i = 1'b0;
    bus.arm_i      = 1'b0;
    bus.edge_sel_i = 2'b00;
    bus.filt_len_i = '0;
    bus.count_i    = CW'(1);
    #5;
    chk("reset_trigger_o", int'(bus.trigger_o), 0);
    chk("reset_armed_o", int'(bus.armed_o), 0);
    chk("reset_done_o", int'(bus.done_o), 0);
    tick(3);
    #2 rst = 1'b0;
    tick(3);

    // Rising, count 1, L = 0: trigger exactly at k + S + 1.
    bus.arm_i = 1'b1;
    tick(3);
    bus.trig_raw_i = 1'b1;
    k = n;
    wait_trig(20, t);
    chk("rise_latency", t, k + S + 1);
    chk("done_with_trigger", int'(bus.done_o), 1);
    tick(2);
    bus.trig_raw_i = 1'b0;
    tick(2);
    bus.arm_i = 1'b0;
    tick(3);

    // Rising, count 3, five 4-cycle pulses: one trigger only.
    bus.count_i = CW'(3);
    bus.arm_i   = 1'b1;
    tick(2);
    base = trig_seen;
    repeat (5) begin
      bus.trig_raw_i = 1'b1;
      tick(4);
      bus.trig_raw_i = 1'b0;
      tick(4);
    end
    tick(4);
    chk("count3_single_trigger", trig_seen - base, 1);
    bus.arm_i = 1'b0;
    tick(3);

    // L = 5: 4-cycle pulse is a glitch, 5-cycle pulse passes (when the filter is built).
    bus.filt_len_i = FW'(5);
    tick(3);
    bus.count_i = CW'(1);
    bus.arm_i   = 1'b1;
    tick(2);
    base = trig_seen;
    bus.trig_raw_i = 1'b1;
    tick(4);
    bus.trig_raw_i = 1'b0;
    tick(12);
    bus.trig_raw_i = 1'b1;
    tick(5);
    bus.trig_raw_i = 1'b0;
    tick(15);
    chk("filter_single_trigger", trig_seen - base, 1);
    bus.arm_i = 1'b0;
    tick(3);
    bus.filt_len_i = '0;
    tick(3);

    // Either edge, count 2: fires on the falling edge.
    bus.edge_sel_i = 2'b10;
    bus.count_i    = CW'(2);
    bus.arm_i      = 1'b1;
    tick(2);
    base = trig_seen;
    bus.trig_raw_i = 1'b1;
    tick(4);
    bus.trig_raw_i = 1'b0;
    tick(8);
    chk("either_single_trigger", trig_seen - base, 1);
    bus.arm_i = 1'b0;
    tick(3);

    // Same, but arm drops in the cycle of the firing event: disarm wins.
    bus.arm_i = 1'b1;
    tick(2);
    base = trig_seen;
    bus.trig_raw_i = 1'b1;
    tick(4);
    bus.trig_raw_i = 1'b0;
    tick(2);
    bus.arm_i = 1'b0;
    tick(6);
    chk("disarm_wins_no_trigger", trig_seen - base, 0);
    chk("disarm_armed_o", int'(bus.armed_o), 0);

    // Level mode with raw already high: trigger one cycle after armed_o rises.
    bus.edge_sel_i = 2'b11;
    bus.trig_raw_i = 1'b1;
    tick(5);
    bus.arm_i = 1'b1;
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      if (bus.armed_o) break;
    end
    @(negedge clk);
    chk("level_trigger_after_armed", int'(bus.trigger_o), 1);
    tick(2);
    bus.arm_i      = 1'b0;
    bus.trig_raw_i = 1'b0;
    tick(4);

    // Reset mid-ARMED with a rising edge in flight: outputs clear at once, no pulse later.
    bus.edge_sel_i = 2'b00;
    bus.count_i    = CW'(1);
    bus.arm_i      = 1'b1;
    tick(3);
    bus.trig_raw_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midreset_trigger_o", int'(bus.trigger_o), 0);
    chk("midreset_armed_o", int'(bus.armed_o), 0);
    chk("midreset_done_o", int'(bus.done_o), 0);
    base = trig_seen;
    bus.arm_i      = 1'b0;
    bus.trig_raw_i = 1'b0;
    tick(1);
    #2 rst = 1'b0;
    tick(10);
    chk("no_pulse_after_reset", trig_seen - base, 0);

    // Randomized phase; the filter length only moves while disarmed.
    for (int it = 0; it < 250; it++) begin
      if (it % 50 == 0) begin
        bus.arm_i = 1'b0;
        tick(3);
        bus.filt_len_i = FW'($urandom_range(0, 4));
        tick(2);
      end
      bus.trig_raw_i = 1'($urandom_range(0, 1));
      bus.arm_i      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.edge_sel_i = 2'($urandom_range(0, 3));
        bus.count_i    = CW'($urandom_range(0, 3));
      end
      tick($urandom_range(1, 6));
    end
    bus.arm_i      = 1'b0;
    bus.trig_raw_i = 1'b0;
    tick(10);
    chk("expected_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
